// File: rtl/sramlike_if.sv
// rtl/sramlike_if.sv - sram-like request/response channel shared by caches and the AXI bridge
interface sramlike_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        addr_ok;
    logic        data_ok;

    modport master (
        output req, wr, size, addr, wdata,
        input  rdata, addr_ok, data_ok
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output rdata, addr_ok, data_ok
    );
endinterface

// File: rtl/sramlike_arbiter.sv
// rtl/sramlike_arbiter.sv - serialises inst/data sram-like requests onto one master channel
module sramlike_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter bit DATA_FIRST   = 1'b1
) (
    input  logic       aclk,
    input  logic       aresetn,
    sramlike_if.slave  inst,
    sramlike_if.slave  data,
    sramlike_if.master m
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ADDR = 2'd1, S_DATA = 2'd2} state_t;

    localparam logic OWN_DATA = 1'b1;

    state_t     state_q, state_d;
    logic       owner_q, owner_d;
    logic [2:0] starve_cnt_q, starve_cnt_d;

    logic pri_req, npri_req, starved, grant_npri, grant_data, owner_req;
    logic addr_ok_own, data_ok_own;

    // "pri" is the default-priority side; the starvation guard protects the other one
    assign pri_req    = DATA_FIRST ? data.req : inst.req;
    assign npri_req   = DATA_FIRST ? inst.req : data.req;
    assign starved    = (starve_cnt_q == 3'(STARVE_LIMIT));
    assign grant_npri = npri_req && (!pri_req || starved);
    assign grant_data = DATA_FIRST ? !grant_npri : grant_npri;
    assign owner_req  = (owner_q == OWN_DATA) ? data.req : inst.req;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_DATA;
            starve_cnt_q <= 3'd0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        starve_cnt_d = starve_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (inst.req || data.req) begin
                    state_d = S_ADDR;
                    owner_d = grant_data;
                end
                // A loss implies the guard was not yet tripped, so +1 never passes the limit
                if (npri_req && !grant_npri)
                    starve_cnt_d = starve_cnt_q + 3'd1;
                else
                    starve_cnt_d = 3'd0;
            end
            S_ADDR: begin
                if (!owner_req)
                    state_d = S_IDLE;
                else if (m.addr_ok)
                    state_d = m.data_ok ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (m.data_ok)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        m.req   = (state_q == S_ADDR) && owner_req;
        m.wr    = (owner_q == OWN_DATA) ? data.wr    : inst.wr;
        m.size  = (owner_q == OWN_DATA) ? data.size  : inst.size;
        m.addr  = (owner_q == OWN_DATA) ? data.addr  : inst.addr;
        m.wdata = (owner_q == OWN_DATA) ? data.wdata : inst.wdata;

        addr_ok_own = (state_q == S_ADDR) && owner_req && m.addr_ok;
        data_ok_own = ((state_q == S_DATA) && m.data_ok) || (addr_ok_own && m.data_ok);

        inst.addr_ok = addr_ok_own && (owner_q != OWN_DATA);
        data.addr_ok = addr_ok_own && (owner_q == OWN_DATA);
        inst.data_ok = data_ok_own && (owner_q != OWN_DATA);
        data.data_ok = data_ok_own && (owner_q == OWN_DATA);
        inst.rdata   = m.rdata;
        data.rdata   = m.rdata;
    end

endmodule
